// File: rtl/imm_decode_stage_pkg.sv
// imm_decode_stage_pkg: immediate type codes and RISC-V opcode constants
package imm_decode_stage_pkg;
    typedef enum logic [2:0] {
        RTYPE  = 3'd0,
        ITYPE  = 3'd1,
        STYPE  = 3'd2,
        BTYPE  = 3'd3,
        UTYPE  = 3'd4,
        JTYPE  = 3'd5,
        SHTYPE = 3'd6,
        ZTYPE  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_OP32    = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
endpackage

// File: rtl/imm_decode_stage_expand.sv
// imm_expand: combinational opcode-driven immediate expansion for RV32/RV64
module imm_expand
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       ty,
    output logic            illegal
);
    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] i32, s32, b32, u32, j32;
    logic [XLEN-1:0] shamt;

    assign op  = instr[6:0];
    assign f3  = instr[14:12];
    assign i32 = {{20{instr[31]}}, instr[31:20]};
    assign s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u32 = {instr[31:12], 12'b0};
    assign j32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt = (!RV64 || op == OP_OPIMM32) ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);

    // pick the immediate format from the opcode; unknown opcodes yield a zero R-type marked illegal
    always_comb begin
        imm     = '0;
        ty      = RTYPE;
        illegal = 1'b0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                ty  = UTYPE;
                imm = XLEN'($signed(u32));
            end
            OP_JAL: begin
                ty  = JTYPE;
                imm = XLEN'($signed(j32));
            end
            OP_JALR, OP_LOAD: begin
                ty  = ITYPE;
                imm = XLEN'($signed(i32));
            end
            OP_STORE: begin
                ty  = STYPE;
                imm = XLEN'($signed(s32));
            end
            OP_BRANCH: begin
                ty  = BTYPE;
                imm = XLEN'($signed(b32));
            end
            OP_OP: ;
            OP_OP32: illegal = !RV64;
            OP_OPIMM, OP_OPIMM32: begin
                if (op == OP_OPIMM32 && !RV64) begin
                    illegal = 1'b1;
                end else if (f3[1:0] == 2'b01) begin
                    ty      = SHTYPE;
                    imm     = shamt;
                    illegal = !RV64 && instr[25];
                end else begin
                    ty  = ITYPE;
                    imm = XLEN'($signed(i32));
                end
            end
            OP_SYSTEM: begin
                ty  = f3[2] ? ZTYPE : ITYPE;
                imm = f3[2] ? XLEN'(instr[19:15]) : XLEN'($signed(i32));
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered ID-stage immediate generator with skid-buffered valid/ready
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);
    localparam int EW = XLEN + 4;

    logic [XLEN-1:0] ex_imm;
    imm_type_e       ex_ty;
    logic            ex_ill;
    logic [EW-1:0]   new_e, out_q, out_d, skid_q, skid_d;
    logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic            in_fire, free;

    imm_expand #(.XLEN(XLEN)) u_expand (
        .instr  (in_instr),
        .imm    (ex_imm),
        .ty     (ex_ty),
        .illegal(ex_ill)
    );

    assign new_e       = {ex_ill, ex_ty, ex_imm};
    assign in_ready    = !rst && (SKID_EN ? !skid_valid_q : (!out_valid_q || out_ready));
    assign in_fire     = in_valid && in_ready;
    assign free        = !out_valid_q || out_ready;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_q[XLEN-1:0];
    assign out_type    = out_q[XLEN+2:XLEN];
    assign out_illegal = out_q[EW-1];

    // output slot refills from the skid first, then from the input; a stalled slot diverts input to the skid
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (free) begin
            out_valid_d  = skid_valid_q || in_fire;
            out_d        = skid_valid_q ? skid_q : in_fire ? new_e : out_q;
            skid_valid_d = 1'b0;
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = new_e;
        end
    end

    // state registers with synchronous reset to an empty stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_q        <= {1'b0, RTYPE, {XLEN{1'b0}}};
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: scoreboard bench driving RV32 and RV64 instances with directed vectors
module tb_imm_decode_stage;
    typedef struct {
        logic [31:0] instr;
        logic [67:0] x32;
        logic [67:0] x64;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in_instr = '0;
    logic        rdy32, rdy64, v32, v64, il32, il64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  t32, t64;

    int checks = 0, errors = 0;
    logic [67:0] q32[$], q64[$];
    logic [67:0] prev[2];
    bit          stall[2];
    vec_t        vecs[16];

    imm_decode_stage #(.XLEN(32), .SKID_EN(1)) d32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_type(t32), .out_illegal(il32)
    );

    imm_decode_stage #(.XLEN(64), .SKID_EN(1)) d64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_type(t64), .out_illegal(il64)
    );

    always #5 clk = ~clk;

    function automatic logic [67:0] e32(input logic [31:0] imm, input logic [2:0] t, input logic il);
        return {il, t, 32'h0, imm};
    endfunction

    function automatic logic [67:0] e64(input logic [63:0] imm, input logic [2:0] t, input logic il);
        return {il, t, imm};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [31:0] ins,
                        input logic [31:0] a, input logic [2:0] at, input logic ai,
                        input logic [63:0] b, input logic [2:0] bt, input logic bi);
        vecs[i] = '{ins, e32(a, at, ai), e64(b, bt, bi)};
    endtask

    task automatic send(input vec_t v);
        bit ok = 0;
        int n = 0;
        in_valid = 1'b1;
        in_instr = v.instr;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (rdy32 && rdy64 && !flush && !rst) begin
                ok = 1;
                q32.push_back(v.x32);
                q64.push_back(v.x64);
            end
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: instr %h not accepted, required acceptance within 50 cycles", v.instr);
        end
    endtask

    task automatic mon(input int w, input logic v, input logic [67:0] a);
        logic [67:0] e;
        if (rst || flush) begin
            if (w == 0) q32.delete(); else q64.delete();
            stall[w] = 0;
        end else begin
            if (stall[w]) chk(w == 0 ? "hold32" : "hold64", {3'b0, v, a}, {3'b0, 1'b1, prev[w]});
            if (v && out_ready) begin
                if ((w == 0 ? q32.size() : q64.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected%0d: got %h with empty scoreboard, required no output", w, a);
                end else begin
                    e = (w == 0) ? q32.pop_front() : q64.pop_front();
                    chk(w == 0 ? "out32" : "out64", {4'b0, a}, {4'b0, e});
                end
            end
            stall[w] = v && !out_ready;
            prev[w]  = a;
        end
    endtask

    always @(negedge clk) begin
        mon(0, v32, {il32, t32, 32'h0, imm32});
        mon(1, v64, {il64, t64, imm64});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        setv(0,  32'hFFF00093, 32'hFFFFFFFF, 3'd1, 0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0);
        setv(1,  32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 0);
        setv(2,  32'h4030D093, 32'h00000003, 3'd6, 0, 64'h3, 3'd6, 0);
        setv(3,  32'h3002D073, 32'h00000005, 3'd7, 0, 64'h5, 3'd7, 0);
        setv(4,  32'h800000B7, 32'h80000000, 3'd4, 0, 64'hFFFFFFFF80000000, 3'd4, 0);
        setv(5,  32'h03F09093, 32'h0000001F, 3'd6, 1, 64'd63, 3'd6, 0);
        setv(6,  32'h00000000, 32'h0, 3'd0, 1, 64'h0, 3'd0, 1);
        setv(7,  32'hFE112C23, 32'hFFFFFFF8, 3'd2, 0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 0);
        setv(8,  32'h008000EF, 32'h00000008, 3'd5, 0, 64'h8, 3'd5, 0);
        setv(9,  32'h002081B3, 32'h0, 3'd0, 0, 64'h0, 3'd0, 0);
        setv(10, 32'h0010809B, 32'h0, 3'd0, 1, 64'h1, 3'd1, 0);
        setv(11, 32'h01F0909B, 32'h0, 3'd0, 1, 64'h1F, 3'd6, 0);
        setv(12, 32'h002080BB, 32'h0, 3'd0, 1, 64'h0, 3'd0, 0);
        setv(13, 32'h12345097, 32'h12345000, 3'd4, 0, 64'h12345000, 3'd4, 0);
        setv(14, 32'h305110F3, 32'h00000305, 3'd1, 0, 64'h305, 3'd1, 0);
        setv(15, 32'hFF013083, 32'hFFFFFFF0, 3'd1, 0, 64'hFFFFFFFFFFFFFFF0, 3'd1, 0);

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {71'b0, rdy32 | rdy64}, 72'd0);
        chk("rst_out_valid", {71'b0, v32 | v64}, 72'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {70'b0, rdy32, rdy64}, 72'd3);
        chk("post_rst_out32", {3'b0, v32, il32, t32, 32'h0, imm32}, {4'b0, e32(0, 0, 0)});
        chk("post_rst_out64", {3'b0, v64, il64, t64, imm64}, {4'b0, e64(0, 0, 0)});
        @(posedge clk); #1;

        send(vecs[0]);
        chk("latency", {70'b0, v32, v64}, 72'd3);
        for (int i = 1; i < 16; i++) send(vecs[i]);
        repeat (4) @(posedge clk);
        #1;
        chk("drain1", 72'(q32.size() + q64.size()), 72'd0);

        out_ready = 1'b0;
        fork
            begin
                send(vecs[0]);
                send(vecs[1]);
                send(vecs[2]);
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready", {70'b0, rdy32, rdy64}, 72'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("no_bubble", {70'b0, v32, v64}, 72'd3);
                end
            end
        join
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("drain2", 72'(q32.size() + q64.size()), 72'd0);

        out_ready = 1'b0;
        send(vecs[3]);
        send(vecs[4]);
        in_valid = 1'b1;
        in_instr = vecs[5].instr;
        flush    = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", {70'b0, v32, v64}, 72'd0);
        chk("flush_in_ready", {70'b0, rdy32, rdy64}, 72'd3);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(vecs[7]);
        send(vecs[8]);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {70'b0, rdy32, rdy64}, 72'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out32", {3'b0, v32, il32, t32, 32'h0, imm32}, {4'b0, e32(0, 0, 0)});
        chk("midrst_out64", {3'b0, v64, il64, t64, imm64}, {4'b0, e64(0, 0, 0)});
        chk("midrst_in_ready1", {70'b0, rdy32, rdy64}, 72'd3);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;

        send(vecs[6]);
        send(vecs[7]);
        repeat (4) @(posedge clk);
        #1;
        chk("drain_final", 72'(q32.size() + q64.size()), 72'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
